// File: rtl/universal_register.sv
// universal_register: parametrised clear/load/count/shift register with a multi-cycle shift-by-N engine
//   clk, rst (async, active-high)       clock and reset
//   cl, ld, inc, dec, sr, sl, start     commands, priority in that order when idle
//   ir, il, shift_mode                  fill bits and shift style (00 serial, 01 rotate, 10 arithmetic, 11 as 00)
//   sat                                 saturating inc/dec
//   in, amt, dir                        load data, multi-cycle shift amount and direction (1 = left)
//   out, carry, zero                    contents, carry/borrow/shifted-out bit, out == 0
//   busy, done                          multi-cycle shift in progress, one-cycle completion pulse
module universal_register #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cl,
  input  logic                       ld,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       sr,
  input  logic                       sl,
  input  logic                       ir,
  input  logic                       il,
  input  logic [WIDTH-1:0]           in,
  input  logic [1:0]                 shift_mode,
  input  logic                       sat,
  input  logic                       start,
  input  logic [$clog2(WIDTH)-1:0]   amt,
  input  logic                       dir,
  output logic [WIDTH-1:0]           out,
  output logic                       carry,
  output logic                       zero,
  output logic                       busy,
  output logic                       done
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, step_r, step_l;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, dir_q, dir_d, done_q, done_d, fill_r, fill_l;
  // Fill bits are sampled every step, so mode changes mid-shift take effect immediately.
  always_comb begin
    fill_r = shift_mode == 2'b01 ? out_q[0] : shift_mode == 2'b10 ? out_q[WIDTH-1] : ir;
    fill_l = shift_mode == 2'b01 ? out_q[WIDTH-1] : shift_mode == 2'b10 ? 1'b0 : il;
    step_r = {fill_r, out_q[WIDTH-1:1]};
    step_l = {out_q[WIDTH-2:0], fill_l};
  end
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (state_q == SHIFT) begin
      if (cl) begin
        out_d   = '0;
        carry_d = 1'b0;
        state_d = IDLE;
      end else begin
        out_d   = dir_q ? step_l : step_r;
        carry_d = dir_q ? out_q[WIDTH-1] : out_q[0];
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end else if (cl) begin
      out_d   = '0;
      carry_d = 1'b0;
    end else if (ld) begin
      out_d   = in;
      carry_d = 1'b0;
    end else if (inc) begin
      carry_d = &out_q;
      out_d   = (sat && &out_q) ? out_q : out_q + ONE;
    end else if (dec) begin
      carry_d = ~|out_q;
      out_d   = (sat && ~|out_q) ? out_q : out_q - ONE;
    end else if (sr) begin
      out_d   = step_r;
      carry_d = out_q[0];
    end else if (sl) begin
      out_d   = step_l;
      carry_d = out_q[WIDTH-1];
    end else if (start) begin
      if (amt == '0) done_d = 1'b1;
      else begin
        cnt_d   = amt;
        dir_d   = dir;
        state_d = SHIFT;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = out_q == '0;
  assign busy  = state_q == SHIFT;
  assign done  = done_q;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: directed and random checks of universal_register against a spec-level model
module tb_universal_register;
  logic clk = 0, rst = 1;
  logic cl = 0, ld = 0, inc = 0, dec = 0, sr = 0, sl = 0, ir = 0, il = 0, sat = 0, start = 0, dir = 0;
  logic [7:0] in = 0;
  logic [1:0] shift_mode = 0;
  logic [2:0] amt = 0;
  logic [7:0] out;
  logic carry, zero, busy, done;
  int total = 0, bad = 0;
  int m_out = 0, m_carry = 0, m_busy = 0, m_done = 0, m_cnt = 0, m_dir = 0;

  universal_register #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .ir(ir), .il(il), .in(in), .shift_mode(shift_mode), .sat(sat), .start(start),
    .amt(amt), .dir(dir), .out(out), .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, int'(out), m_out);
    chk({tag, ".carry"}, int'(carry), m_carry);
    chk({tag, ".zero"}, int'(zero), int'(m_out == 0));
    chk({tag, ".busy"}, int'(busy), m_busy);
    chk({tag, ".done"}, int'(done), m_done);
  endtask

  // One shift step as plain arithmetic on an 8-bit value; d = 1 means left.
  task automatic m_shift(input int d);
    int mode;
    mode = (shift_mode == 2'b11) ? 0 : int'(shift_mode);
    if (d == 0) begin
      m_carry = m_out & 1;
      if (mode == 1) m_out = ((m_out >> 1) | (m_out << 7)) & 255;
      else if (mode == 2) m_out = (m_out >> 1) | (m_out & 128);
      else m_out = (m_out >> 1) | (int'(ir) << 7);
    end else begin
      m_carry = (m_out >> 7) & 1;
      if (mode == 1) m_out = ((m_out << 1) | (m_out >> 7)) & 255;
      else if (mode == 2) m_out = (m_out << 1) & 255;
      else m_out = ((m_out << 1) | int'(il)) & 255;
    end
  endtask

  task automatic m_edge();
    int nd;
    nd = 0;
    if (m_busy != 0) begin
      if (cl) begin m_out = 0; m_carry = 0; m_busy = 0; end
      else begin
        m_shift(m_dir);
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_busy = 0; nd = 1; end
      end
    end else if (cl) begin m_out = 0; m_carry = 0; end
    else if (ld) begin m_out = int'(in); m_carry = 0; end
    else if (inc) begin
      if (m_out == 255) begin m_carry = 1; if (!sat) m_out = 0; end
      else begin m_out = m_out + 1; m_carry = 0; end
    end else if (dec) begin
      if (m_out == 0) begin m_carry = 1; if (!sat) m_out = 255; end
      else begin m_out = m_out - 1; m_carry = 0; end
    end else if (sr) m_shift(0);
    else if (sl) m_shift(1);
    else if (start) begin
      if (amt == 0) nd = 1;
      else begin m_cnt = int'(amt); m_dir = int'(dir); m_busy = 1; end
    end
    m_done = nd;
  endtask

  task automatic idle_cmds();
    cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0; start = 0;
  endtask

  task automatic cyc(input string tag);
    m_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
    idle_cmds();
  endtask

  initial begin
    #2;
    chk_all("reset");
    @(posedge clk); #1;
    rst = 0;
    // Rotate right 0xA5 by 3
    ld = 1; in = 8'hA5; cyc("ld_a5");
    shift_mode = 2'b01; start = 1; amt = 3; dir = 0; cyc("rot_start");
    chk("rot_busy0", int'(busy), 1);
    cyc("rot1"); chk("rot1_val", int'(out), 'hD2);
    cyc("rot2"); chk("rot2_val", int'(out), 'h69);
    cyc("rot3"); chk("rot3_val", int'(out), 'hB4);
    chk("rot3_carry", int'(carry), 1);
    chk("rot3_done", int'(done), 1);
    cyc("rot_after"); chk("rot_done_clr", int'(done), 0);
    // Wrap vs saturate
    ld = 1; in = 8'hFF; cyc("ld_ff");
    inc = 1; sat = 0; cyc("inc_wrap");
    chk("inc_wrap_val", int'(out), 0); chk("inc_wrap_zero", int'(zero), 1); chk("inc_wrap_c", int'(carry), 1);
    ld = 1; in = 8'hFF; cyc("ld_ff2");
    inc = 1; sat = 1; cyc("inc_sat");
    chk("inc_sat_val", int'(out), 'hFF); chk("inc_sat_c", int'(carry), 1);
    ld = 1; in = 8'h00; cyc("ld_00");
    dec = 1; sat = 1; cyc("dec_sat");
    chk("dec_sat_val", int'(out), 0); chk("dec_sat_c", int'(carry), 1);
    dec = 1; sat = 0; cyc("dec_wrap");
    chk("dec_wrap_val", int'(out), 'hFF);
    // Arithmetic and serial shifts
    ld = 1; in = 8'h90; cyc("ld_90");
    shift_mode = 2'b10; sr = 1; cyc("asr1");
    chk("asr1_val", int'(out), 'hC8); chk("asr1_c", int'(carry), 0);
    sr = 1; cyc("asr2"); chk("asr2_val", int'(out), 'hE4);
    ld = 1; in = 8'h81; cyc("ld_81");
    shift_mode = 2'b00; il = 1; sl = 1; cyc("ssl");
    chk("ssl_val", int'(out), 'h03); chk("ssl_c", int'(carry), 1);
    il = 0;
    // Busy lockout and abort
    ld = 1; in = 8'h0F; cyc("ld_0f");
    start = 1; amt = 5; dir = 1; cyc("lock_start");
    ld = 1; in = 8'h33; cyc("lock1"); chk("lock1_val", int'(out), 'h1E);
    cyc("lock2");
    cl = 1; cyc("abort");
    chk("abort_val", int'(out), 0); chk("abort_busy", int'(busy), 0); chk("abort_done", int'(done), 0);
    cyc("abort_after"); chk("abort_nodone", int'(done), 0);
    // Zero amount, re-pulse and priority
    ld = 1; in = 8'h10; cyc("ld_10");
    start = 1; amt = 0; cyc("amt0");
    chk("amt0_done", int'(done), 1); chk("amt0_busy", int'(busy), 0); chk("amt0_out", int'(out), 'h10);
    start = 1; amt = 0; cyc("amt0_again"); chk("amt0_repulse", int'(done), 1);
    cyc("amt0_clr"); chk("amt0_clr_done", int'(done), 0);
    inc = 1; dec = 1; cyc("inc_dec"); chk("inc_wins", int'(out), 'h11);
    // Reset mid-shift
    ld = 1; in = 8'h5A; cyc("ld_5a");
    start = 1; amt = 5; dir = 1; cyc("rst_start");
    cyc("rst_s1"); cyc("rst_s2");
    #2; rst = 1; #1;
    m_out = 0; m_carry = 0; m_busy = 0; m_done = 0;
    chk_all("rst_async");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk_all("rst_release");
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cl = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 7) == 0);
      inc = ($urandom_range(0, 5) == 0);
      dec = ($urandom_range(0, 5) == 0);
      sr = ($urandom_range(0, 5) == 0);
      sl = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 3) == 0);
      in = 8'($urandom);
      amt = 3'($urandom);
      dir = 1'($urandom);
      ir = 1'($urandom);
      il = 1'($urandom);
      sat = 1'($urandom);
      shift_mode = 2'($urandom);
      cyc("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/universal_register.md
# universal_register

Parametrised general-purpose datapath register, the next generation of the 4-bit clear/load/inc/dec/shift register. It adds configurable width, rotate and arithmetic shift modes, optional saturating count, a carry/borrow flag and a multi-cycle shift-by-N engine with a busy/done handshake. It sits in the simulation datapath wherever a controller needs an accumulator, counter or barrel-free shifter.

## Interface

- WIDTH, 8, data width in bits; legal values are 2 or more.
- AMT_W, $clog2(WIDTH), width of the shift-amount port. This is a localparam.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cl  in  1  clear.
- ld  in  1  load `in`.
- inc  in  1  increment.
- dec  in  1  decrement.
- sr  in  1  single shift right.
- sl  in  1  single shift left.
- ir  in  1  serial fill bit for right shifts.
- il  in  1  serial fill bit for left shifts.
- in  in  WIDTH  parallel load data.
- shift_mode  in  2  shift mode:
  - 00: serial fill, using ir/il.
  - 01: rotate.
  - 10: arithmetic. Right shift replicates the MSB; left shift fills 0.
  - 11: treated as 00.
- sat  in  1  when 1, inc/dec saturate instead of wrapping.
- start  in  1  begin a multi-cycle shift.
- amt  in  AMT_W  number of positions for the multi-cycle shift.
- dir  in  1  multi-cycle direction: 0 = right, 1 = left.
- out  out  WIDTH  register contents.
- carry  out  1  carry, borrow or shifted-out bit.
- zero  out  1  combinational, equals (out == 0).
- busy  out  1  multi-cycle shift in progress.
- done  out  1  one-cycle pulse when a multi-cycle shift completes.

## Operation

- **Reset:** rst high forces out=0, carry=0, busy=0, done=0 and state IDLE immediately. It has priority over everything, including mid-shift. The in-progress shift is lost and done does not pulse.
- **States:** IDLE and SHIFT.
- **Command priority in IDLE:** cl > ld > inc > dec > sr > sl > start. Only the highest asserted command acts on the edge. With none asserted, out and carry hold.
- **cl / ld:** out=0 or out=in respectively; carry=0.
- **inc, sat=0:** out+1 modulo 2^WIDTH; carry=1 if out was all-ones, else 0.
- **inc, sat=1:** at all-ones, out holds and carry=1; otherwise out+1 and carry=0.
- **dec, sat=0:** out-1 modulo 2^WIDTH; carry (borrow)=1 if out was 0, else 0.
- **dec, sat=1:** at 0, out holds and carry=1; otherwise out-1 and carry=0.
- **Single step, right:** carry=out[0]. New MSB:
  - mode 00: ir
  - mode 01: old out[0]
  - mode 10: old out[WIDTH-1]
- **Single step, left:** carry=out[WIDTH-1]. New LSB:
  - mode 00: il
  - mode 01: old MSB
  - mode 10: 0
- **sr / sl:** one step right or left in the current shift_mode.
- **start with amt=0:** out and carry unchanged; done=1 for the following cycle; stays IDLE.
- **start with amt=k>0:** latch k into a down-counter and latch dir. shift_mode, ir and il are not latched; they are sampled on every step. Go to SHIFT with busy=1. No data change on the start edge.
- **SHIFT:** each edge performs one step in the latched dir and decrements the counter. On the edge where the counter goes 1→0: go to IDLE, busy=0, done=1.
- **While busy:** ld, inc, dec, sr, sl and start are ignored.
- **Abort:** cl while busy clears out and carry, sets busy=0, goes to IDLE, and done does not pulse.
- **Clearing done:** done deasserts on the next edge unless another completion occurs on that edge. A start with amt=0 issued the cycle done is high re-pulses done.

## Timing

- **Single-cycle commands:** result visible on out after one edge.
- **Multi-cycle shift:** start sampled at edge E0.
  - busy=1 from E0 through Ek.
  - out after edge Ej (1≤j≤k) equals j steps applied.
  - After Ek: busy=0, done=1 and out is final. Total latency is k+1 edges including the start edge.
- zero follows out combinationally, with no added latency.
- Next start is accepted in the cycle done is high; busy is already low then.

## Test plan

- **Reset mid-shift:** ld 0x5A, start amt=5 dir=1; assert rst asynchronously after 2 steps -> out=0x00, carry=0, busy=0 immediately; done stays 0.
- **Rotate right:** ld 0xA5, shift_mode=01, start amt=3 dir=0 -> out goes 0xD2, 0x69, 0xB4; carry=1 at end; busy high 3 cycles; done pulses once.
- **Wrap vs saturate:**
  - ld 0xFF, inc with sat=0 -> out=0x00, carry=1, zero=1.
  - Repeat with sat=1 -> out=0xFF, carry=1.
  - ld 0x00, dec with sat=1 -> out=0x00, carry=1.
- **Arithmetic and serial shifts:**
  - ld 0x90, shift_mode=10, sr -> 0xC8 with carry=0; sr again -> 0xE4.
  - shift_mode=00, il=1, sl from 0x81 -> 0x03, carry=1.
- **Busy lockout and abort:** ld 0x0F, start amt=5 dir=1; pulse ld with in=0x33 during busy -> ignored, out=0x1E after step 1; cl at step 3 -> out=0x00, busy=0, no done.
- **Zero amount and priority:** start amt=0 -> done=1 after one edge, busy never 1, out unchanged. Assert inc and dec together from 0x10 -> 0x11 (inc wins).
